shift_rs: RTL and testbench



---
 rtl/shift_rs.sv | 155 +++++++++++++++
 tb/tb_shift_rs.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rs.sv
// shift_rs: single-entry reservation station feeding one shift unit.
// It accepts one issued shift, snoops the CDB for missing source operands,
// dispatches once both are present, and then holds its tag until the
// paired shifter broadcasts that tag on the CDB.
// The CDB is a packed vector {tag, val}, with the tag in the upper TAG_W bits.
module shift_rs #(
    parameter int              TAG_W = 4,
    parameter int              OP_W  = 3,
    parameter logic [TAG_W-1:0] TAG  = 4'd5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [OP_W-1:0]     issue_op_i,
    input  logic [TAG_W-1:0]    issue_qj_i,
    input  logic [31:0]         issue_vj_i,
    input  logic [TAG_W-1:0]    issue_qk_i,
    input  logic [31:0]         issue_vk_i,
    input  logic [TAG_W+31:0]   cdb_i,
    input  logic                flush_i,
    output logic [OP_W-1:0]     fu_oper_o,
    output logic [31:0]         fu_rs1_val_o,
    output logic [31:0]         fu_rs2_val_o,
    output logic                fu_ready_o,
    output logic                busy_o,
    output logic                illegal_op_o
);

    localparam logic [TAG_W-1:0] NO_VAL = '0;

    localparam logic [OP_W-1:0] SRLR = 3'd0;
    localparam logic [OP_W-1:0] SRLI = 3'd1;
    localparam logic [OP_W-1:0] SRAR = 3'd2;
    localparam logic [OP_W-1:0] SRAI = 3'd3;
    localparam logic [OP_W-1:0] SLLR = 3'd4;
    localparam logic [OP_W-1:0] SLLI = 3'd5;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_EXEC  = 2'd3;

    logic [1:0]       state;
    logic [OP_W-1:0]  op_q;
    logic [TAG_W-1:0] qj_q, qk_q;
    logic [31:0]      vj_q, vk_q;
    logic             illegal_q;

    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_val;
    logic             op_legal;

    assign cdb_tag  = cdb_i[TAG_W+31:32];
    assign cdb_val  = cdb_i[31:0];
    assign op_legal = issue_op_i inside {SRLR, SRLI, SRAR, SRAI, SLLR, SLLI};

    // Resolve issued operands, including a same-cycle CDB bypass.
    logic [TAG_W-1:0] iss_qj, iss_qk;
    logic [31:0]      iss_vj, iss_vk;
    always_comb begin
        iss_qj = issue_qj_i;
        iss_vj = issue_vj_i;
        iss_qk = issue_qk_i;
        iss_vk = issue_vk_i;
        if (issue_qj_i != NO_VAL && cdb_tag == issue_qj_i) begin
            iss_qj = NO_VAL;
            iss_vj = cdb_val;
        end
        if (issue_qk_i != NO_VAL && cdb_tag == issue_qk_i) begin
            iss_qk = NO_VAL;
            iss_vk = cdb_val;
        end
    end

    // Capture stored operands from the CDB while waiting; a NO_VAL tag never matches.
    logic [TAG_W-1:0] w_qj, w_qk;
    logic [31:0]      w_vj, w_vk;
    always_comb begin
        w_qj = qj_q;
        w_vj = vj_q;
        w_qk = qk_q;
        w_vk = vk_q;
        if (qj_q != NO_VAL && cdb_tag == qj_q) begin
            w_qj = NO_VAL;
            w_vj = cdb_val;
        end
        if (qk_q != NO_VAL && cdb_tag == qk_q) begin
            w_qk = NO_VAL;
            w_vk = cdb_val;
        end
    end

    // Entry state machine: reset first, then flush, then normal progress.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= S_EMPTY;
            op_q      <= SRLR;
            qj_q      <= NO_VAL;
            qk_q      <= NO_VAL;
            vj_q      <= '0;
            vk_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (flush_i) begin
                state <= S_EMPTY;
                qj_q  <= NO_VAL;
                qk_q  <= NO_VAL;
            end else begin
                case (state)
                    S_EMPTY: begin
                        if (issue_valid_i) begin
                            if (op_legal) begin
                                op_q  <= issue_op_i;
                                qj_q  <= iss_qj;
                                vj_q  <= iss_vj;
                                qk_q  <= iss_qk;
                                vk_q  <= iss_vk;
                                state <= (iss_qj == NO_VAL && iss_qk == NO_VAL) ? S_READY : S_WAIT;
                            end else begin
                                illegal_q <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        qj_q <= w_qj;
                        vj_q <= w_vj;
                        qk_q <= w_qk;
                        vk_q <= w_vk;
                        if (w_qj == NO_VAL && w_qk == NO_VAL)
                            state <= S_READY;
                    end
                    // The shifter always accepts, so dispatch lasts exactly one cycle.
                    S_READY: state <= S_EXEC;
                    // Our tag stays reserved until the shifter's own broadcast appears.
                    S_EXEC: begin
                        if (cdb_tag == TAG)
                            state <= S_EMPTY;
                    end
                    default: state <= S_EMPTY;
                endcase
            end
        end
    end

    assign issue_ready_o = (state == S_EMPTY);
    assign busy_o        = !issue_ready_o;
    assign fu_ready_o    = (state == S_READY) && !flush_i;
    assign fu_oper_o     = op_q;
    assign fu_rs1_val_o  = vj_q;
    assign fu_rs2_val_o  = vk_q;
    assign illegal_op_o  = illegal_q;

endmodule

// File: tb/tb_shift_rs.sv
// tb_shift_rs: drives shift_rs with directed and random issues, plays the
// CDB producers and the paired shifter, and checks dispatches and broadcasts
// against expectations queued when each instruction is issued.
module tb_shift_rs;

    localparam int         TAG_W = 4;
    localparam logic [3:0] TAG   = 4'd5;
    localparam logic [3:0] T_A   = 4'd3;
    localparam logic [3:0] NOV   = 4'd0;

    localparam logic [2:0] SRLR = 3'd0, SRLI = 3'd1, SRAR = 3'd2,
                           SRAI = 3'd3, SLLR = 3'd4, SLLI = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [3:0]  issue_qj, issue_qk;
    logic [31:0] issue_vj, issue_vk;
    logic [35:0] cdb, cdb_drv;
    logic        flush;
    logic [2:0]  fu_oper;
    logic [31:0] fu_rs1, fu_rs2;
    logic        fu_ready, busy, illegal;

    // Shifter model: latches at dispatch and broadcasts TAG the next cycle.
    logic        sh_bc = 1'b0;
    logic [31:0] sh_val = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] res_q[$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    assign cdb = sh_bc ? {TAG, sh_val} : cdb_drv;

    shift_rs #(.TAG_W(TAG_W), .OP_W(3), .TAG(TAG)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_op_i(issue_op), .issue_qj_i(issue_qj), .issue_vj_i(issue_vj),
        .issue_qk_i(issue_qk), .issue_vk_i(issue_vk), .cdb_i(cdb), .flush_i(flush),
        .fu_oper_o(fu_oper), .fu_rs1_val_o(fu_rs1), .fu_rs2_val_o(fu_rs2),
        .fu_ready_o(fu_ready), .busy_o(busy), .illegal_op_o(illegal)
    );

    function automatic logic [31:0] ref_shift(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        if (op == SRLR || op == SRLI)      return a >> sh;
        else if (op == SRAR || op == SRAI) return $unsigned($signed(a) >>> sh);
        else                               return a << sh;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        sh_bc <= fu_ready;
        if (fu_ready) sh_val <= ref_shift(fu_oper, fu_rs1, fu_rs2);
    end

    // Monitor: every dispatch and every shifter broadcast consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && fu_ready) begin
            if (exp_q.size() == 0) chk("spurious_dispatch", 32'd1, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("dispatch_op", {29'd0, fu_oper}, {29'd0, mon_e.op});
                chk("dispatch_rs1", fu_rs1, mon_e.a);
                chk("dispatch_rs2", fu_rs2, mon_e.b);
                res_q.push_back(mon_e.r);
            end
        end
        if (sh_bc) begin
            if (res_q.size() == 0) chk("spurious_broadcast", 32'd1, 32'd0);
            else chk("broadcast_val", sh_val, res_q.pop_front());
        end
    end

    function automatic logic [35:0] idle_cdb();
        return {NOV, 32'($urandom)};
    endfunction

    function automatic logic [3:0] rand_tag();
        logic [3:0] t;
        do t = 4'($urandom_range(1, 15)); while (t == TAG);
        return t;
    endfunction

    task automatic expect_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.r = ref_shift(op, a, b);
        exp_q.push_back(e);
    endtask

    // Presents an issue for one cycle (with an optional CDB value that cycle).
    task automatic do_issue(logic [2:0] op, logic [3:0] qj, logic [31:0] vj,
                            logic [3:0] qk, logic [31:0] vk, logic [35:0] c);
        issue_valid = 1'b1;
        issue_op = op; issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
        cdb_drv = c;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        cdb_drv = idle_cdb();
    endtask

    task automatic bcast(logic [3:0] t, logic [31:0] v);
        cdb_drv = {t, v};
        @(posedge clk); #1;
        cdb_drv = idle_cdb();
    endtask

    task automatic wait_empty(string name);
        int n;
        n = 0;
        while (!issue_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {31'd0, issue_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [3:0]  qj, qk;
        logic [31:0] vj, vk, pj, pk;
        logic        byp;

        rst_n = 1'b0; issue_valid = 1'b0; flush = 1'b0;
        issue_op = '0; issue_qj = '0; issue_qk = '0; issue_vj = '0; issue_vk = '0;
        cdb_drv = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fu_ready", {31'd0, fu_ready}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_rs1", fu_rs1, 32'd0);
        chk("rst_rs2", fu_rs2, 32'd0);
        chk("rst_op", {29'd0, fu_oper}, {29'd0, SRLR});
        @(posedge clk); #1;

        // 1: both operands ready at issue; check the full latency chain.
        expect_op(SLLI, 32'h1, 32'h4);
        do_issue(SLLI, NOV, 32'h1, NOV, 32'h4, idle_cdb());
        @(negedge clk);
        chk("t1_fu_ready_n1", {31'd0, fu_ready}, 32'd1);
        @(negedge clk);
        chk("t1_cdb_tag_n2", {28'd0, cdb[35:32]}, {28'd0, TAG});
        chk("t1_cdb_val_n2", cdb[31:0], 32'h10);
        chk("t1_busy_n2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_issue_ready_n3", {31'd0, issue_ready}, 32'd1);
        @(posedge clk); #1;

        // 2: rs1 pending; no dispatch until the producer broadcasts.
        expect_op(SRAR, 32'h8000_0000, 32'h4);
        do_issue(SRAR, T_A, 32'hDEAD_BEEF, NOV, 32'h4, idle_cdb());
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_busy_wait", {31'd0, busy}, 32'd1);
            chk("t2_no_dispatch", {31'd0, fu_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bcast(T_A, 32'h8000_0000);
        @(negedge clk);
        chk("t2_dispatch", {31'd0, fu_ready}, 32'd1);
        @(posedge clk); #1;
        wait_empty("t2_drain");

        // 3: both operands captured from one bypassed broadcast.
        expect_op(SRLR, 32'hF0, 32'hF0);
        do_issue(SRLR, T_A, 32'h1, T_A, 32'h2, {T_A, 32'hF0});
        @(negedge clk);
        chk("t3_dispatch", {31'd0, fu_ready}, 32'd1);
        @(posedge clk); #1;
        wait_empty("t3_drain");

        // 4: flush while READY suppresses dispatch and frees the entry.
        do_issue(SRLI, NOV, 32'h7, NOV, 32'h1, idle_cdb());
        flush = 1'b1;
        @(negedge clk);
        chk("t4_flush_no_dispatch", {31'd0, fu_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t4_issue_ready", {31'd0, issue_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_tag", {31'd0, cdb[35:32] == TAG}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;

        // 5: illegal op pulses illegal_op_o exactly one cycle.
        do_issue(3'd6, NOV, 32'h1, NOV, 32'h1, idle_cdb());
        @(negedge clk);
        chk("t5_illegal_pulse", {31'd0, illegal}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t5_illegal_clear", {31'd0, illegal}, 32'd0);
        chk("t5_busy2", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Flush with an issue in EMPTY: dropped, and no illegal pulse even for a bad op.
        flush = 1'b1;
        do_issue(3'd7, NOV, 32'h1, NOV, 32'h1, idle_cdb());
        do_issue(SLLR, NOV, 32'h1, NOV, 32'h1, idle_cdb());
        flush = 1'b0;
        @(negedge clk);
        chk("flush_empty_busy", {31'd0, busy}, 32'd0);
        chk("flush_empty_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk); #1;

        // 6: reset while waiting discards the entry; a later broadcast is ignored.
        do_issue(SRLR, T_A, 32'h0, NOV, 32'h1, idle_cdb());
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cdb_drv = {T_A, 32'h5};
        @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        cdb_drv = idle_cdb();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_dispatch", {31'd0, fu_ready}, 32'd0);
        end
        @(posedge clk); #1;

        // Random issues: operand values are planned up front so expectations are known at issue.
        for (int n = 0; n < 40; n++) begin
            op  = 3'($urandom_range(0, 5));
            qj  = ($urandom_range(0, 1) == 1) ? rand_tag() : NOV;
            qk  = ($urandom_range(0, 2) == 0) ? qj : (($urandom_range(0, 1) == 1) ? rand_tag() : NOV);
            vj  = $urandom; vk = $urandom; pj = $urandom; pk = $urandom;
            if (qk == qj) pk = pj;
            byp = (qj != NOV) && ($urandom_range(0, 2) == 0);
            expect_op(op, (qj == NOV) ? vj : pj, (qk == NOV) ? vk : pk);
            do_issue(op, qj, vj, qk, vk, byp ? {qj, pj} : idle_cdb());
            if (qj != NOV && !byp) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                bcast(qj, pj);
            end
            if (qk != NOV && qk != qj) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                bcast(qk, pk);
            end
            wait_empty("rand_drain");
        end

        repeat (3) @(posedge clk);
        chk("exp_queue_empty", exp_q.size(), 32'd0);
        chk("res_queue_empty", res_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
